// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the TX FIFO write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_arb_pkg;

  // Write-side sequencer states; the ALU word always takes LO then HI back to back.
  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_SEND_RD     = 2'd1,
    ST_SEND_ALU_LO = 2'd2,
    ST_SEND_ALU_HI = 2'd3
  } arb_state_t;

  // Requester IDs: index into the ovf flags and the value held in last_grant.
  localparam logic REQ_RD  = 1'b0;
  localparam logic REQ_ALU = 1'b1;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundles the requester inputs and the FIFO write-side signals of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: fifo_full travels toward the arbiter; everything else is a pulse or a level.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [2*WIDTH-1:0] alu_out;
  logic               alu_vld;
  logic [WIDTH-1:0]   rd_data;
  logic               rd_vld;
  logic               fifo_full;
  logic               ovf_clr;
  logic [WIDTH-1:0]   wr_data;
  logic               wr_inc;
  logic               busy;
  logic [1:0]         ovf;

  // Side that feeds requests and observes FIFO writes.
  modport master (
    output alu_out, alu_vld, rd_data, rd_vld, fifo_full, ovf_clr,
    input  wr_data, wr_inc, busy, ovf
  );

  // The arbiter itself.
  modport slave (
    input  alu_out, alu_vld, rd_data, rd_vld, fifo_full, ovf_clr,
    output wr_data, wr_inc, busy, ovf
  );
endinterface

// File: rtl/arb_hold_slot.sv
// One-deep hold register for a pulse-only requester; flags drops when a pulse hits a busy slot.
// Latency: data visible on data_out the cycle after the load pulse.
// Backpressure: none upstream; a pulse landing on a pending slot that is not unloading is dropped.
module arb_hold_slot #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] data_in,
  input  logic          unload,
  output logic [DW-1:0] data_out,
  output logic          pending,
  output logic          drop
);

  logic [DW-1:0] data_q;
  logic          pend_q;

  // A slot accepts a pulse when empty or when its last byte leaves this very cycle.
  logic accept;
  assign accept = load && (!pend_q || unload);
  assign drop   = load && pend_q && !unload;

  // Slot storage: reload wins over unload so a same-cycle pulse keeps the slot pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      pend_q <= 1'b0;
    end else if (accept) begin
      data_q <= data_in;
      pend_q <= 1'b1;
    end else if (unload) begin
      pend_q <= 1'b0;
    end
  end

  assign data_out = data_q;
  assign pending  = pend_q;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the TX FIFO write port between the reg-file read slot and the 2-byte ALU slot (round-robin on ties).
// Latency: pulse at t -> first wr_inc at t+2; ALU bytes go out on two adjacent write cycles; one idle cycle between items.
// Backpressure: fifo_full stalls the current byte with state and data held; pulses into a busy slot are dropped and flagged in ovf.
// Build option FIFO_ARB_MSB_FIRST_EN: send the ALU high byte first (state order and timing unchanged).
module fifo_wr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.slave  bus
);
  import fifo_arb_pkg::*;

  arb_state_t         state_q, state_d;
  logic               last_q, last_d;
  logic [1:0]         ovf_q;

  logic [WIDTH-1:0]   rd_q;
  logic [2*WIDTH-1:0] alu_q;
  logic               rd_pend, alu_pend;
  logic               rd_drop, alu_drop;
  logic               rd_rel, alu_rel;
  logic               wr_inc;
  logic [WIDTH-1:0]   wr_data;
  logic [WIDTH-1:0]   alu_first, alu_second;

`ifdef FIFO_ARB_MSB_FIRST_EN
  assign alu_first  = alu_q[2*WIDTH-1:WIDTH];
  assign alu_second = alu_q[WIDTH-1:0];
`else
  assign alu_first  = alu_q[WIDTH-1:0];
  assign alu_second = alu_q[2*WIDTH-1:WIDTH];
`endif

  // A slot is freed only when its final byte is actually written.
  assign rd_rel  = (state_q == ST_SEND_RD)     && wr_inc;
  assign alu_rel = (state_q == ST_SEND_ALU_HI) && wr_inc;

  arb_hold_slot #(.DW(WIDTH)) u_rd_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (bus.rd_vld),
    .data_in  (bus.rd_data),
    .unload   (rd_rel),
    .data_out (rd_q),
    .pending  (rd_pend),
    .drop     (rd_drop)
  );

  arb_hold_slot #(.DW(2*WIDTH)) u_alu_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (bus.alu_vld),
    .data_in  (bus.alu_out),
    .unload   (alu_rel),
    .data_out (alu_q),
    .pending  (alu_pend),
    .drop     (alu_drop)
  );

  // State register and round-robin pointer; reset leaves ALU as last winner so RD takes the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= REQ_ALU;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next state and write-port drive; last_grant only moves when both slots contend.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wr_inc  = 1'b0;
    wr_data = '0;
    case (state_q)
      ST_IDLE: begin
        if (rd_pend && alu_pend) begin
          if (last_q == REQ_ALU) begin
            state_d = ST_SEND_RD;
            last_d  = REQ_RD;
          end else begin
            state_d = ST_SEND_ALU_LO;
            last_d  = REQ_ALU;
          end
        end else if (rd_pend) begin
          state_d = ST_SEND_RD;
        end else if (alu_pend) begin
          state_d = ST_SEND_ALU_LO;
        end
      end
      ST_SEND_RD: begin
        wr_data = rd_q;
        wr_inc  = !bus.fifo_full;
        if (!bus.fifo_full) state_d = ST_IDLE;
      end
      ST_SEND_ALU_LO: begin
        wr_data = alu_first;
        wr_inc  = !bus.fifo_full;
        if (!bus.fifo_full) state_d = ST_SEND_ALU_HI;
      end
      ST_SEND_ALU_HI: begin
        wr_data = alu_second;
        wr_inc  = !bus.fifo_full;
        if (!bus.fifo_full) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset abandons a half-sent word: the pending byte must not reach the FIFO.
    if (rst) wr_inc = 1'b0;
  end

  // Sticky drop flags; a drop in the same cycle as ovf_clr still sets its bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 2'b00;
    end else begin
      ovf_q <= (bus.ovf_clr ? 2'b00 : ovf_q) | {alu_drop, rd_drop};
    end
  end

  assign bus.wr_inc  = wr_inc;
  assign bus.wr_data = wr_data;
  assign bus.busy    = rd_pend || alu_pend || (state_q != ST_IDLE);
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, a set/clear race sequence, then random traffic vs a queue model.
module tb_fifo_wr_arbiter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.WIDTH(W)) bus ();

  fifo_wr_arbiter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte order of an ALU word as it should appear in the FIFO.
  function automatic logic [7:0] first_b(input logic [15:0] w);
`ifdef FIFO_ARB_MSB_FIRST_EN
    return w[15:8];
`else
    return w[7:0];
`endif
  endfunction

  function automatic logic [7:0] second_b(input logic [15:0] w);
`ifdef FIFO_ARB_MSB_FIRST_EN
    return w[7:0];
`else
    return w[15:8];
`endif
  endfunction

  typedef struct {
    logic        r;
    logic        rv;
    logic [7:0]  rd;
    logic        av;
    logic [15:0] ao;
    logic        full;
    logic        clr;
    logic        e_inc;
    logic [7:0]  e_dat;
    logic        e_busy;
    logic [1:0]  e_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic rv, input logic [7:0] rd,
                              input logic av, input logic [15:0] ao, input logic full,
                              input logic clr, input logic e_inc, input logic [7:0] e_dat,
                              input logic e_busy, input logic [1:0] e_ovf);
    vec_t v;
    v.r = r; v.rv = rv; v.rd = rd; v.av = av; v.ao = ao; v.full = full; v.clr = clr;
    v.e_inc = e_inc; v.e_dat = e_dat; v.e_busy = e_busy; v.e_ovf = e_ovf;
    tbl.push_back(v);
  endfunction

  task automatic drive(input logic r, input logic rv, input logic [7:0] rd, input logic av,
                       input logic [15:0] ao, input logic full, input logic clr);
    rst           = r;
    bus.rd_vld    = rv;
    bus.rd_data   = rd;
    bus.alu_vld   = av;
    bus.alu_out   = ao;
    bus.fifo_full = full;
    bus.ovf_clr   = clr;
  endtask

  task automatic chk_out(input string tag, input logic inc, input logic [7:0] dat,
                         input logic bsy, input logic [1:0] ovf);
    chk({tag, "_inc"},  bus.wr_inc,  inc);
    chk({tag, "_dat"},  bus.wr_data, dat);
    chk({tag, "_busy"}, bus.busy,    bsy);
    chk({tag, "_ovf"},  bus.ovf,     ovf);
  endtask

  // Reference model state: per-requester slots plus the byte queue of the item being sent.
  bit         m_pend[2];
  logic [15:0] m_data[2];
  logic [7:0] m_job[$];
  int         m_owner;
  int         m_last;
  logic [1:0] m_ovf;

  initial begin
    bit         rel[2];
    bit         was_idle;
    int         g;
    logic [1:0] n_ovf;
    bit         r, rv, av, full, clr, req;
    logic [7:0] rd;
    logic [15:0] ao, dat;
    logic       e_inc;
    logic [7:0] e_dat;
    logic       e_busy;

    drive(1, 0, 8'h00, 0, 16'h0000, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_out("reset", 1'b0, 8'h00, 1'b0, 2'b00);
    @(posedge clk); #1;

    // Single read-data item.
    add(0,1,8'hA5,0,16'h0,0,0, 0,8'h00,0,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 0,8'h00,1,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 1,8'hA5,1,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 0,8'h00,0,2'b00);
    // Single ALU word.
    add(0,0,8'h00,1,16'h1234,0,0, 0,8'h00,0,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 0,8'h00,1,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 1,first_b(16'h1234),1,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 1,second_b(16'h1234),1,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 0,8'h00,0,2'b00);
    // Tie after reset: RD first, then the tie pointer hands the next tie to ALU.
    add(1,0,8'h00,0,16'h0,0,0, 0,8'h00,0,2'b00);
    add(0,1,8'h11,1,16'hBEEF,0,0, 0,8'h00,0,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 0,8'h00,1,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 1,8'h11,1,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 0,8'h00,1,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 1,first_b(16'hBEEF),1,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 1,second_b(16'hBEEF),1,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 0,8'h00,0,2'b00);
    add(0,1,8'h33,1,16'h4455,0,0, 0,8'h00,0,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 0,8'h00,1,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 1,first_b(16'h4455),1,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 1,second_b(16'h4455),1,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 0,8'h00,1,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 1,8'h33,1,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 0,8'h00,0,2'b00);
    // FIFO full for 5 cycles from the grant.
    add(0,0,8'h00,1,16'h5678,0,0, 0,8'h00,0,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 0,8'h00,1,2'b00);
    for (int i = 0; i < 5; i++)
      add(0,0,8'h00,0,16'h0,1,0, 0,first_b(16'h5678),1,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 1,first_b(16'h5678),1,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 1,second_b(16'h5678),1,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 0,8'h00,0,2'b00);
    // Overflow on the read slot while blocked, then clear.
    add(0,1,8'h11,0,16'h0,1,0, 0,8'h00,0,2'b00);
    add(0,0,8'h00,0,16'h0,1,0, 0,8'h00,1,2'b00);
    add(0,0,8'h00,0,16'h0,1,0, 0,8'h11,1,2'b00);
    add(0,1,8'h22,0,16'h0,1,0, 0,8'h11,1,2'b00);
    add(0,0,8'h00,0,16'h0,1,0, 0,8'h11,1,2'b01);
    add(0,0,8'h00,0,16'h0,0,0, 1,8'h11,1,2'b01);
    add(0,0,8'h00,0,16'h0,0,0, 0,8'h00,0,2'b01);
    add(0,0,8'h00,0,16'h0,0,1, 0,8'h00,0,2'b01);
    add(0,0,8'h00,0,16'h0,0,0, 0,8'h00,0,2'b00);
    // Reset between the two ALU bytes: second byte never written.
    add(0,0,8'h00,1,16'hCAFE,0,0, 0,8'h00,0,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 0,8'h00,1,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 1,first_b(16'hCAFE),1,2'b00);
    add(1,0,8'h00,0,16'h0,0,0, 0,second_b(16'hCAFE),1,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 0,8'h00,0,2'b00);
    add(0,0,8'h00,0,16'h0,0,0, 0,8'h00,0,2'b00);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].rv, tbl[i].rd, tbl[i].av, tbl[i].ao, tbl[i].full, tbl[i].clr);
      @(negedge clk);
      chk_out($sformatf("vec%0d", i), tbl[i].e_inc, tbl[i].e_dat, tbl[i].e_busy, tbl[i].e_ovf);
      @(posedge clk); #1;
    end

    // Drop coinciding with ovf_clr: the set must win.
    drive(0, 1, 8'h44, 0, 16'h0, 1, 0);
    @(posedge clk); #1;
    drive(0, 1, 8'h55, 0, 16'h0, 1, 0);
    @(posedge clk); #1;
    drive(0, 1, 8'h66, 0, 16'h0, 1, 1);
    @(negedge clk);
    chk("race_ovf_before", bus.ovf, 2'b01);
    @(posedge clk); #1;
    drive(0, 0, 8'h00, 0, 16'h0, 1, 1);
    @(negedge clk);
    chk("race_ovf_set_wins", bus.ovf, 2'b01);
    chk("race_inc_blocked", bus.wr_inc, 1'b0);
    @(posedge clk); #1;
    drive(0, 0, 8'h00, 0, 16'h0, 0, 0);
    @(negedge clk);
    chk("race_ovf_cleared", bus.ovf, 2'b00);
    chk("race_inc", bus.wr_inc, 1'b1);
    chk("race_dat", bus.wr_data, 8'h44);
    @(posedge clk); #1;
    @(negedge clk);
    chk("race_idle_busy", bus.busy, 1'b0);
    @(posedge clk); #1;

    // Random traffic against the queue model; cycle 0 resets both sides.
    m_pend[0] = 0; m_pend[1] = 0;
    m_data[0] = '0; m_data[1] = '0;
    m_job.delete();
    m_owner = 0; m_last = 1; m_ovf = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      r    = (c == 0) || ($urandom_range(0, 99) == 0);
      rv   = ($urandom_range(0, 3) == 0);
      av   = ($urandom_range(0, 3) == 0);
      full = ($urandom_range(0, 2) == 0);
      clr  = ($urandom_range(0, 15) == 0);
      rd   = 8'($urandom);
      ao   = 16'($urandom);
      drive(r, rv, rd, av, ao, full, clr);
      @(negedge clk);
      e_inc  = (m_job.size() > 0) && !full && !r;
      e_dat  = (m_job.size() > 0) ? m_job[0] : 8'h00;
      e_busy = m_pend[0] || m_pend[1] || (m_job.size() > 0);
      chk_out($sformatf("rnd%0d", c), e_inc, e_dat, e_busy, m_ovf);

      if (r) begin
        m_pend[0] = 0; m_pend[1] = 0;
        m_job.delete();
        m_last = 1; m_ovf = 2'b00;
      end else begin
        rel[0] = 0; rel[1] = 0;
        was_idle = (m_job.size() == 0);
        if (!was_idle && !full) begin
          void'(m_job.pop_front());
          if (m_job.size() == 0) rel[m_owner] = 1;
        end
        if (was_idle) begin
          g = -1;
          if (m_pend[0] && m_pend[1]) begin
            g = (m_last == 1) ? 0 : 1;
            m_last = g;
          end else if (m_pend[0]) g = 0;
          else if (m_pend[1]) g = 1;
          if (g == 0) m_job.push_back(m_data[0][7:0]);
          if (g == 1) begin
            m_job.push_back(first_b(m_data[1]));
            m_job.push_back(second_b(m_data[1]));
          end
          if (g >= 0) m_owner = g;
        end
        n_ovf = clr ? 2'b00 : m_ovf;
        for (int k = 0; k < 2; k++) begin
          req = (k == 0) ? rv : av;
          dat = (k == 0) ? {8'h00, rd} : ao;
          if (req) begin
            if (!m_pend[k] || rel[k]) begin
              m_data[k] = dat;
              m_pend[k] = 1;
            end else begin
              n_ovf[k] = 1'b1;
            end
          end else if (rel[k]) begin
            m_pend[k] = 0;
          end
        end
        m_ovf = n_ovf;
      end
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
